// File: rtl/ram_4x8_bist_pkg.sv
// +----------------------------------------------------------------------+
// | ram_bist_pkg : March C- table, state type and backgrounds  Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

package ram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_ELEM = 6;

  localparam logic [7:0] B0 = 8'h00;
  localparam logic [7:0] B1 = 8'hFF;

  // One bit per march element, bit index = element number.
  // The second op of an element is always a write.
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN   = 6'b011000;
  localparam logic [NUM_ELEM-1:0] FIRST_IS_WR = 6'b000001;
  localparam logic [NUM_ELEM-1:0] FIRST_ONE   = 6'b010100;
  localparam logic [NUM_ELEM-1:0] HAS_SECOND  = 6'b011110;
  localparam logic [NUM_ELEM-1:0] SECOND_ONE  = 6'b001010;

  function automatic logic op_is_write(input logic [2:0] elem, input logic second);
    return second ? 1'b1 : FIRST_IS_WR[elem];
  endfunction

  function automatic logic op_data_one(input logic [2:0] elem, input logic second);
    return second ? SECOND_ONE[elem] : FIRST_ONE[elem];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_4x8_bist_if.sv
// +----------------------------------------------------------------------+
// | ram_4x8_bist_if : BIST-side RAM bus (addr/D/we out, Q in)  Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

interface ram_4x8_bist_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_addr, output ram_d, output ram_we, input  ram_q);
  modport slave  (input  ram_addr, input  ram_d, input  ram_we, output ram_q);
endinterface

`default_nettype wire

// File: rtl/ram_4x8_bist_march_seq.sv
// +----------------------------------------------------------------------+
// | march_seq : element/address/op counters and table decode   Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module march_seq
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [2:0]        cur_elem,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_write,
  output logic [DATA_W-1:0] cur_data,
  output logic              cur_last,
  output logic              nxt_write,
  output logic [ADDR_W-1:0] nxt_addr,
  output logic [DATA_W-1:0] nxt_data
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [2:0]        LAST_ELEM = 3'(NUM_ELEM - 1);

  logic [2:0]        elem;
  logic [ADDR_W-1:0] addr;
  logic              second;

  logic [2:0]        n_elem;
  logic [ADDR_W-1:0] n_addr;
  logic              n_second;
  logic              at_end;
  logic              more_ops;

  always_comb begin
    at_end   = ELEM_DOWN[elem] ? (addr == '0) : (addr == ADDR_MAX);
    more_ops = !second && HAS_SECOND[elem];
    n_elem   = elem;
    n_addr   = addr;
    n_second = 1'b0;
    if (more_ops) begin
      n_second = 1'b1;
    end else if (at_end) begin
      // Element change is the only place the address wraps.
      n_elem = (elem == LAST_ELEM) ? 3'd0 : elem + 3'd1;
      n_addr = ELEM_DOWN[n_elem] ? ADDR_MAX : '0;
    end else begin
      n_addr = ELEM_DOWN[elem] ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  always_comb begin
    cur_elem  = elem;
    cur_addr  = addr;
    cur_write = op_is_write(elem, second);
    cur_data  = {DATA_W{op_data_one(elem, second)}};
    cur_last  = (elem == LAST_ELEM) && at_end && !more_ops;
    nxt_write = op_is_write(n_elem, n_second);
    nxt_addr  = n_addr;
    nxt_data  = {DATA_W{op_data_one(n_elem, n_second)}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem   <= 3'd0;
      addr   <= '0;
      second <= 1'b0;
    end else if (load) begin
      elem   <= 3'd0;
      addr   <= ELEM_DOWN[0] ? ADDR_MAX : '0;
      second <= 1'b0;
    end else if (advance) begin
      elem   <= n_elem;
      addr   <= n_addr;
      second <= n_second;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_4x8_bist.sv
// +----------------------------------------------------------------------+
// | ram_4x8_bist : March C- BIST controller for RAM4x8         Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module ram_4x8_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  ram_4x8_bist_if.master    ram
);

  state_t state;
  state_t state_nxt;

  logic [2:0]        cur_elem;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_write;
  logic [DATA_W-1:0] cur_data;
  logic              cur_last;
  logic              nxt_write;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;

  logic load;
  logic advance;
  logic mismatch;
  logic run_end;

  march_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .cur_elem  (cur_elem),
    .cur_addr  (cur_addr),
    .cur_write (cur_write),
    .cur_data  (cur_data),
    .cur_last  (cur_last),
    .nxt_write (nxt_write),
    .nxt_addr  (nxt_addr),
    .nxt_data  (nxt_data)
  );

  always_comb begin
    state_nxt = state;
    mismatch  = (state == RUN) && !cur_write && (ram.ram_q != cur_data);
    run_end   = (state == RUN) && (mismatch || cur_last);
    load      = (state == IDLE) && start;
    advance   = (state == RUN) && !run_end;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (run_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bus registers always hold the op being executed this cycle, so they
  // are loaded with the following op at every non-terminal RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_elem    <= 3'd0;
      fail_addr    <= '0;
      fail_data    <= '0;
      ram.ram_we   <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_d    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy         <= 1'b1;
            pass         <= 1'b0;
            fail_elem    <= 3'd0;
            fail_addr    <= '0;
            fail_data    <= '0;
            ram.ram_we   <= op_is_write(3'd0, 1'b0);
            ram.ram_addr <= ELEM_DOWN[0] ? '1 : '0;
            ram.ram_d    <= {DATA_W{op_data_one(3'd0, 1'b0)}};
          end
        end
        RUN: begin
          if (run_end) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            ram.ram_we <= 1'b0;
            if (mismatch) begin
              fail_elem <= cur_elem;
              fail_addr <= cur_addr;
              fail_data <= ram.ram_q;
            end else begin
              pass <= 1'b1;
            end
          end else begin
            ram.ram_we   <= nxt_write;
            ram.ram_addr <= nxt_addr;
            ram.ram_d    <= nxt_data;
          end
        end
        DONE: done <= 1'b0;
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_4x8_bist.sv
// +----------------------------------------------------------------------+
// | tb_ram_4x8_bist : bench with faulty RAM and March C- model  Rev 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ram_4x8_bist;
  import ram_bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_elem;
  logic [1:0] fail_addr;
  logic [7:0] fail_data;

  int errors = 0;
  int checks = 0;

  // Fault environment: 0 none, 1 stuck-at bit, 2 coupling (agg write B1 -> vic = B1)
  int f_mode = 0;
  int f_addr = 0;
  int f_bit  = 0;
  bit f_val  = 1'b0;
  int agg    = 1;
  int vic    = 0;

  logic [7:0] mem      [4];
  logic [7:0] init_mem [4];
  logic       init_req = 1'b0;
  int         wr_count = 0;

  bit         exp_ok;
  int         exp_k;
  int         exp_elem;
  int         exp_addr;
  int         exp_data;
  int         exp_writes;
  logic [7:0] exp_mem [4];

  ram_4x8_bist_if #(.ADDR_W(2), .DATA_W(8)) bus ();

  ram_4x8_bist #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_elem (fail_elem),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM4x8 with optional fault
  always_comb begin
    logic [7:0] q;
    q = mem[bus.ram_addr];
    if (f_mode == 1 && int'(bus.ram_addr) == f_addr) q[f_bit] = f_val;
    bus.ram_q = q;
  end

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 4; i++) mem[i] <= init_mem[i];
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_d;
      if (f_mode == 2 && int'(bus.ram_addr) == agg && bus.ram_d == B1) mem[vic] <= B1;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load_mem();
    @(negedge clk);
    for (int i = 0; i < 4; i++) init_mem[i] = 8'($urandom);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // March C- applied op by op to a copy of the current memory.
  task automatic model_run();
    logic [7:0] m [4];
    int rd  [6];
    int wrv [6];
    int k;
    int a;
    logic [7:0] q;
    logic [7:0] ev;
    rd  = '{-1, 0, 1, 0, 1, 0};
    wrv = '{0, 1, 0, 1, 0, -1};
    for (int i = 0; i < 4; i++) m[i] = mem[i];
    exp_ok = 1'b1; k = 0; exp_writes = 0;
    exp_k = 0; exp_elem = 0; exp_addr = 0; exp_data = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 4; i++) begin
        a = (e == 3 || e == 4) ? 3 - i : i;
        if (exp_ok && rd[e] >= 0) begin
          k++;
          q = m[a];
          if (f_mode == 1 && a == f_addr) q[f_bit] = f_val;
          ev = (rd[e] == 1) ? B1 : B0;
          if (q !== ev) begin
            exp_ok = 1'b0; exp_k = k; exp_elem = e; exp_addr = a; exp_data = int'(q);
          end
        end
        if (exp_ok && wrv[e] >= 0) begin
          k++;
          exp_writes++;
          m[a] = (wrv[e] == 1) ? B1 : B0;
          if (f_mode == 2 && a == agg && wrv[e] == 1) m[vic] = B1;
        end
      end
    end
    if (exp_ok) exp_k = k;
    for (int i = 0; i < 4; i++) exp_mem[i] = m[i];
  endtask

  task automatic run_and_check(input string tag, input bit do_pulse, input int glitch_at, input bit hold);
    int w0;
    int dcyc;
    model_run();
    w0 = wr_count;
    if (do_pulse) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk({tag, ".busy_first"}, 32'(busy), 32'd1);
    chk({tag, ".we_first"},   32'(bus.ram_we), 32'd1);
    chk({tag, ".addr_first"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, ".d_first"},    32'(bus.ram_d), 32'h00);
    chk({tag, ".pass_clr"},   32'(pass), 32'd0);
    chk({tag, ".felem_clr"},  32'(fail_elem), 32'd0);
    chk({tag, ".faddr_clr"},  32'(fail_addr), 32'd0);
    chk({tag, ".fdata_clr"},  32'(fail_data), 32'd0);
    dcyc = -1;
    for (int c = 2; c <= 60; c++) begin
      @(posedge clk); #1;
      if (glitch_at > 0 && c == glitch_at) start = 1'b1;
      if (glitch_at > 0 && c == glitch_at + 1 && !hold) start = 1'b0;
      if (done) begin
        dcyc = c;
        break;
      end
    end
    chk({tag, ".done_cycle"}, 32'(dcyc), 32'(exp_k + 1));
    chk({tag, ".busy_end"},   32'(busy), 32'd0);
    chk({tag, ".pass"},       32'(pass), 32'(exp_ok));
    chk({tag, ".fail_elem"},  32'(fail_elem), 32'(exp_elem));
    chk({tag, ".fail_addr"},  32'(fail_addr), 32'(exp_addr));
    chk({tag, ".fail_data"},  32'(fail_data), 32'(exp_data));
    chk({tag, ".writes"},     32'(wr_count - w0), 32'(exp_writes));
    for (int i = 0; i < 4; i++) chk({tag, ".mem"}, 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".busy_idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    chk("rst.felem", 32'(fail_elem), 32'd0);
    chk("rst.faddr", 32'(fail_addr), 32'd0);
    chk("rst.fdata", 32'(fail_data), 32'd0);
    chk("rst.we", 32'(bus.ram_we), 32'd0);
    chk("rst.addr", 32'(bus.ram_addr), 32'd0);
    chk("rst.d", 32'(bus.ram_d), 32'd0);
    rst_n = 1'b1;

    // Fault-free run
    f_mode = 0;
    load_mem();
    run_and_check("clean", 1'b1, 0, 1'b0);
    idle_after("clean");

    // Bit 3 of address 2 stuck at 0
    f_mode = 1; f_addr = 2; f_bit = 3; f_val = 1'b0;
    load_mem();
    run_and_check("sa0_a2b3", 1'b1, 0, 1'b0);
    idle_after("sa0_a2b3");

    // Coupling: writing B1 to address 1 forces address 0 to B1
    f_mode = 2; agg = 1; vic = 0;
    load_mem();
    run_and_check("cf_1to0", 1'b1, 0, 1'b0);
    idle_after("cf_1to0");

    // start re-pulsed during RUN cycle 10
    f_mode = 0;
    load_mem();
    run_and_check("glitch", 1'b1, 10, 1'b0);
    idle_after("glitch");

    // Asynchronous reset in RUN cycle 20 (an E2 write)
    load_mem();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("arst.we_before", 32'(bus.ram_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.we", 32'(bus.ram_we), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.pass", 32'(pass), 32'd0);
    chk("arst.addr", 32'(bus.ram_addr), 32'd0);
    chk("arst.d", 32'(bus.ram_d), 32'd0);
    chk("arst.felem", 32'(fail_elem), 32'd0);
    w0 = wr_count;
    repeat (3) @(posedge clk);
    #1;
    chk("arst.no_writes", 32'(wr_count - w0), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_and_check("post_rst", 1'b1, 0, 1'b0);
    idle_after("post_rst");

    // Back-to-back with start held: failing run, then fault-free run
    f_mode = 1; f_addr = 2; f_bit = 3; f_val = 1'b0;
    load_mem();
    run_and_check("b2b_1", 1'b1, 0, 1'b1);
    @(posedge clk); #1;
    chk("b2b.idle_busy", 32'(busy), 32'd0);
    chk("b2b.held_elem", 32'(fail_elem), 32'd2);
    f_mode = 0;
    run_and_check("b2b_2", 1'b0, 0, 1'b0);
    idle_after("b2b_2");

    // Random stuck-at faults over random initial contents
    for (int r = 0; r < 4; r++) begin
      f_mode = 1;
      f_addr = int'($urandom_range(0, 3));
      f_bit  = int'($urandom_range(0, 7));
      f_val  = 1'($urandom);
      load_mem();
      run_and_check("rand_sa", 1'b1, 0, 1'b0);
      idle_after("rand_sa");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_4x8_bist.md
# ram_4x8_bist

- March C- built-in self-test controller sitting directly upstream of `RAM4x8`.
- While testing, it owns the RAM's `addr`/`D`/`we` inputs, consumes `Q`, and reports pass/fail with first-failure diagnostics.
- The parent muxes functional traffic and BIST traffic onto the RAM; this block drives only the BIST side.

## Interface
Parameters:
- `ADDR_W`, 2, RAM address width (4 words)
- `DATA_W`, 8, RAM word width

Ports:
- `clk`  in  1  rising-edge clock shared with `RAM4x8`
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a test run, sampled in IDLE only
- `busy`  out  1  high while the march sequence runs
- `done`  out  1  one-cycle pulse when a run ends
- `pass`  out  1  result of the last run; held until the next start
- `fail_elem`  out  3  march element index of the first mismatch
- `fail_addr`  out  ADDR_W  address of the first mismatch
- `fail_data`  out  DATA_W  `Q` value captured at the first mismatch
- `ram_addr`  out  ADDR_W  to RAM `addr`
- `ram_d`  out  DATA_W  to RAM `D`
- `ram_we`  out  1  to RAM `we`
- `ram_q`  in  DATA_W  from RAM `Q`

## Operation
RAM contract:
- Write is captured at the rising edge while `we`=1.
- `Q` shows `mem[addr]` combinationally within the same cycle.

March C- sequence, with background B0=8'h00 and B1=8'hFF:
- E0 ⇑(w0)
- E1 ⇑(r0,w1)
- E2 ⇑(r1,w0)
- E3 ⇓(r0,w1)
- E4 ⇓(r1,w0)
- E5 ⇑(r0)

Address order: ⇑ = 0,1,2,3; ⇓ = 3,2,1,0.

Operations:
- One operation per cycle; read-then-write at the same address uses two consecutive cycles.
- Total: 4+8+8+8+8+4 = 40 RUN cycles.
- Read op: `ram_we`=0. At the closing rising edge, `ram_q` is compared to the expected background.
- Write op: `ram_we`=1, `ram_d` = background.

FSM:
- IDLE: `start`=1 → RUN, and `pass` is cleared to 0 at that edge.
- RUN → DONE after the last E5 read compares equal; `pass`=1.
- RUN → DONE immediately on the first mismatch. `fail_elem`/`fail_addr`/`fail_data` are captured at that edge and `pass` stays 0.
- DONE → IDLE unconditionally after one cycle.

Other rules:
- `start` in RUN/DONE is ignored.
- `fail_*` hold their values until the next start, which clears them to 0.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_*`=0, `ram_we`=0, `ram_addr`=0, `ram_d`=0, state=IDLE.
- Reset asserted mid-run aborts immediately; `ram_we` drops asynchronously and no further writes occur.
- `start` is sampled at edge T0. Cycle T0+1: `busy`=1, `ram_addr`=0, `ram_we`=1, `ram_d`=8'h00.
- Fault-free run: last RUN cycle is T0+40. `done`=1, `busy`=0, `pass`=1 in cycle T0+41. State is IDLE at T0+42.
- Mismatch in RUN cycle k: `done` pulses in cycle k+1 and `busy` falls in the same cycle.
- Element boundaries need no bubble cycles. Address wraps 3→0 (⇑) or 0→3 (⇓) only at an element change.
- `start` held high through DONE does not restart. It is next sampled in IDLE, so a back-to-back run begins at the earliest cycle IDLE is re-entered.

## Structure
- Package `ram_bist_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - element count (6);
  - the per-element march table constants: direction, first-op type and data, second-op presence and data;
  - background constants B0/B1.
- Sub-module `march_seq`: element/address/op counters plus table decode, producing the current op, address, expected data and last-op flag.
- The top level keeps the FSM, the compare logic and the result registers.
- `RAM4x8` is instantiated by the parent, not inside this block.

## Test plan
- Fault-free behavioural RAM, `start` pulse at T0 → `busy` 40 cycles, `done`=1 and `pass`=1 at T0+41. Final memory is 8'h00 at every address.
- Bit 3 of address 2 stuck-at-0 → mismatch on the 5th op of E2 (RUN cycle 17). Results: `fail_elem`=2, `fail_addr`=2, `fail_data`=8'hF7, `pass`=0. `done` pulses at T0+18.
- Coupling fault (write 1 to addr 1 forces addr 0 to 1) → `fail_elem`=3, `fail_addr`=0, `fail_data`=8'hFF, `pass`=0.
- `start` re-pulsed during RUN at cycle 10 → ignored. Run still ends at T0+41 and total write count is unchanged.
- `rst_n` low at RUN cycle 20 → `ram_we`=0 immediately and all outputs at reset values. A new `start` after release completes a full 40-cycle pass.
- Two consecutive starts → second run clears `pass`/`fail_*` at its start edge and reports independently.
